// File: rtl/pong_pkg.sv
// Shared Pong constants, FSM state encoding and direction encoding.
// The paddle stage takes PADDLE_HEIGHT from here as well.
package pong_pkg;

    localparam int H_RES         = 640;
    localparam int V_RES         = 480;
    localparam int BALL_SIZE     = 8;
    localparam int BALL_STEP     = 2;
    localparam int PADDLE_X_R    = 35;
    localparam int PADDLE_HEIGHT = 50;

    typedef logic [2:0] step_t;

    localparam step_t      STEP_INIT  = step_t'(BALL_STEP);
    localparam step_t      STEP_MAX   = 3'd4;
    localparam logic [9:0] X_MAX      = 10'(H_RES - BALL_SIZE);
    localparam logic [9:0] Y_MAX      = 10'(V_RES - BALL_SIZE);
    localparam logic [9:0] X_CENTRE   = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CENTRE   = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0] X_RETURN   = 10'(PADDLE_X_R + 1);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2
    } state_e;

    // 1 = moving right (x) or down (y)
    localparam logic DIR_NEG = 1'b0;
    localparam logic DIR_POS = 1'b1;

endpackage

// File: rtl/ball_axis.sv
// Single-axis ball mover: steps the position toward 0 or hi_i, clamping at
// both ends; reflects at hi_i always and at 0 only when REFLECT_LO is set.
module ball_axis
    import pong_pkg::*;
#(
    parameter bit REFLECT_LO = 1'b1
) (
    input  logic [9:0] pos_i,
    input  logic       dir_i,
    input  step_t      step_i,
    input  logic [9:0] hi_i,
    output logic [9:0] pos_o,
    output logic       dir_o
);

    logic [10:0] pos_w;
    logic [10:0] step_w;
    logic [10:0] sum_w;

    // 11-bit compares so neither end of the range can wrap
    assign pos_w  = {1'b0, pos_i};
    assign step_w = 11'(step_i);
    assign sum_w  = pos_w + step_w;

    always_comb begin
        pos_o = pos_i;
        dir_o = dir_i;
        if (dir_i == DIR_POS) begin
            if (sum_w >= {1'b0, hi_i}) begin
                pos_o = hi_i;
                dir_o = DIR_NEG;
            end else begin
                pos_o = sum_w[9:0];
            end
        end else begin
            if (pos_w <= step_w) begin
                pos_o = '0;
                if (REFLECT_LO) begin
                    dir_o = DIR_POS;
                end
            end else begin
                pos_o = pos_i - 10'(step_i);
            end
        end
    end

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball engine: serve/play/miss FSM, wall and left-paddle reflection.
// Define BALL_SPEEDUP_EN to grow the step by 1 on every 4th hit (cap 4).
module ball_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_TICKS = 60
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       refr_tick,
    input  logic [9:0] paddle_y,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       hit,
    output logic       miss,
    output logic       playing,
    output logic [7:0] hits
);

    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_TICKS - 1);
    localparam logic [10:0] PAD_FRONT  = 11'(PADDLE_X_R);
    localparam logic [10:0] BALL_SZ    = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_H      = 11'(PADDLE_HEIGHT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        vx_q, vx_d, vy_q, vy_d;
    logic        hit_q, hit_d, miss_q, miss_d;
    logic [7:0]  hits_q, hits_d;
    step_t       step;

`ifdef BALL_SPEEDUP_EN
    step_t       step_q, step_d;
    assign step = step_q;
`else
    assign step = STEP_INIT;
`endif

    logic [9:0]  ax_pos, ay_pos;
    logic        ax_dir, ay_dir;

    ball_axis #(.REFLECT_LO(1'b0)) u_axis_x (
        .pos_i (x_q),
        .dir_i (vx_q),
        .step_i(step),
        .hi_i  (X_MAX),
        .pos_o (ax_pos),
        .dir_o (ax_dir)
    );

    ball_axis #(.REFLECT_LO(1'b1)) u_axis_y (
        .pos_i (y_q),
        .dir_i (vy_q),
        .step_i(step),
        .hi_i  (Y_MAX),
        .pos_o (ay_pos),
        .dir_o (ay_dir)
    );

    logic [10:0] x_w, y_w, pad_w, step_w;
    logic        paddle_hit, ball_lost;
    logic [7:0]  hits_inc;

    assign x_w    = {1'b0, x_q};
    assign y_w    = {1'b0, y_q};
    assign pad_w  = {1'b0, paddle_y};
    assign step_w = 11'(step);

    // Strict overlap on both vertical edges: a graze is not a hit
    assign paddle_hit = (vx_q == DIR_NEG) && (x_w > PAD_FRONT) &&
                        (x_w <= PAD_FRONT + step_w) &&
                        (y_w + BALL_SZ > pad_w) && (y_w < pad_w + PAD_H);
    assign ball_lost  = (vx_q == DIR_NEG) && (x_w < step_w);
    assign hits_inc   = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SERVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (refr_tick) begin
            case (state_q)
                SERVE:   if (serve || cnt_q == SERVE_LAST) state_d = PLAY;
                PLAY:    if (!paddle_hit && ball_lost) state_d = MISS;
                MISS:    state_d = SERVE;
                default: state_d = SERVE;
            endcase
        end
    end

    always_comb begin
        playing = (state_q == PLAY);
    end

    always_comb begin
        cnt_d  = cnt_q;
        x_d    = x_q;
        y_d    = y_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        hits_d = hits_q;
        hit_d  = 1'b0;
        miss_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
        step_d = step_q;
`endif
        if (refr_tick) begin
            case (state_q)
                SERVE: cnt_d = (state_d == PLAY) ? 8'd0 : cnt_q + 8'd1;
                PLAY: begin
                    y_d  = ay_pos;
                    vy_d = ay_dir;
                    if (paddle_hit) begin
                        x_d    = X_RETURN;
                        vx_d   = DIR_POS;
                        hit_d  = 1'b1;
                        hits_d = hits_inc;
`ifdef BALL_SPEEDUP_EN
                        if (hits_inc[1:0] == 2'b00 && step_q < STEP_MAX)
                            step_d = step_q + 3'd1;
`endif
                    end else if (ball_lost) begin
                        x_d    = '0;
                        miss_d = 1'b1;
                    end else begin
                        x_d  = ax_pos;
                        vx_d = ax_dir;
                    end
                end
                MISS: begin
                    x_d    = X_CENTRE;
                    y_d    = Y_CENTRE;
                    vx_d   = DIR_POS;
                    vy_d   = DIR_POS;
                    hits_d = '0;
`ifdef BALL_SPEEDUP_EN
                    step_d = STEP_INIT;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            x_q    <= X_CENTRE;
            y_q    <= Y_CENTRE;
            vx_q   <= DIR_POS;
            vy_q   <= DIR_POS;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            hits_q <= '0;
`ifdef BALL_SPEEDUP_EN
            step_q <= STEP_INIT;
`endif
        end else begin
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            y_q    <= y_d;
            vx_q   <= vx_d;
            vy_q   <= vy_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
            hits_q <= hits_d;
`ifdef BALL_SPEEDUP_EN
            step_q <= step_d;
`endif
        end
    end

    assign ball_x = x_q;
    assign ball_y = y_q;
    assign hit    = hit_q;
    assign miss   = miss_q;
    assign hits   = hits_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: fixed trajectory table, hit/miss/reset
// sequences, then randomized play against a signed-velocity reference model.
module tb_ball_ctrl;

`ifdef BALL_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       refr_tick;
    logic [9:0] paddle_y;
    logic       serve;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       hit;
    logic       miss;
    logic       playing;
    logic [7:0] hits;

    ball_ctrl dut (
        .clk      (clk),
        .rstn     (rstn),
        .refr_tick(refr_tick),
        .paddle_y (paddle_y),
        .serve    (serve),
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .hit      (hit),
        .miss     (miss),
        .playing  (playing),
        .hits     (hits)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: mode 0 waiting to serve, 1 in rally, 2 ball just lost
    int m_mode, m_cnt, m_x, m_y, m_sx, m_sy, m_step, m_hits;
    bit m_hit, m_miss;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_x = 316; m_y = 236;
        m_sx = 1; m_sy = 1; m_step = 2; m_hits = 0;
        m_hit = 0; m_miss = 0;
    endtask

    task automatic model_tick(input bit srv, input int pad);
        int nx, ny;
        m_hit  = 0;
        m_miss = 0;
        case (m_mode)
            0: begin
                if (srv || m_cnt == 59) begin
                    m_mode = 1;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
            1: begin
                nx = m_x + m_sx * m_step;
                ny = m_y + m_sy * m_step;
                if (m_sx < 0 && m_x > 35 && nx <= 35 && m_y + 8 > pad && m_y < pad + 50) begin
                    m_x = 36; m_sx = 1; m_hit = 1;
                    if (m_hits < 255) begin
                        m_hits++;
                        if (SPEEDUP && m_hits % 4 == 0 && m_step < 4) m_step++;
                    end
                end else if (nx < 0) begin
                    m_x = 0; m_miss = 1; m_mode = 2;
                end else if (nx >= 632) begin
                    m_x = 632; m_sx = -1;
                end else begin
                    m_x = nx;
                end
                if (ny <= 0) begin
                    m_y = 0; m_sy = 1;
                end else if (ny >= 472) begin
                    m_y = 472; m_sy = -1;
                end else begin
                    m_y = ny;
                end
            end
            default: begin
                m_x = 316; m_y = 236; m_sx = 1; m_sy = 1;
                m_step = 2; m_hits = 0; m_mode = 0;
            end
        endcase
    endtask

    task automatic do_clk(input bit tick);
        refr_tick = tick;
        @(posedge clk);
        #1;
        refr_tick = 1'b0;
        if (tick) model_tick(serve, int'(paddle_y));
        else begin
            m_hit  = 0;
            m_miss = 0;
        end
    endtask

    task automatic check_model(input string tag);
        vectors++;
        $display("%s: x=%0d y=%0d play=%0b hits=%0d hit=%0b miss=%0b", tag,
                 ball_x, ball_y, playing, hits, hit, miss);
        if (ball_x !== 10'(m_x) || ball_y !== 10'(m_y) || playing !== (m_mode == 1) ||
            hits !== 8'(m_hits) || hit !== m_hit || miss !== m_miss) begin
            miscompares++;
            $display("FAIL %s: got x=%0d y=%0d play=%0b hits=%0d hit=%0b miss=%0b, want x=%0d y=%0d play=%0b hits=%0d hit=%0b miss=%0b",
                     tag, ball_x, ball_y, playing, hits, hit, miss,
                     m_x, m_y, (m_mode == 1), m_hits, m_hit, m_miss);
        end
    endtask

    task automatic check_exp(input string tag, input int ex, input int ey, input bit ep,
                             input int eh, input bit ehit, input bit emiss);
        vectors++;
        $display("%s: x=%0d y=%0d play=%0b hits=%0d hit=%0b miss=%0b", tag,
                 ball_x, ball_y, playing, hits, hit, miss);
        if (ball_x !== 10'(ex) || ball_y !== 10'(ey) || playing !== ep ||
            hits !== 8'(eh) || hit !== ehit || miss !== emiss) begin
            miscompares++;
            $display("FAIL %s: got x=%0d y=%0d play=%0b hits=%0d hit=%0b miss=%0b, want x=%0d y=%0d play=%0b hits=%0d hit=%0b miss=%0b",
                     tag, ball_x, ball_y, playing, hits, hit, miss, ex, ey, ep, eh, ehit, emiss);
        end
    endtask

    // Reset is checked before any clock edge arrives, proving it is asynchronous
    task automatic apply_reset(input string tag);
        rstn = 1'b0;
        #2;
        model_reset();
        check_exp(tag, 316, 236, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic int track_pad(input int y);
        return (y - 21 < 0) ? 0 : y - 21;
    endfunction

    typedef struct {
        bit do_rst;
        bit srv;
        int n_ticks;
        int ex;
        int ey;
        bit eplay;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bool_seq();
    end

    task automatic bool_seq();
        bit done;
        rstn = 1'b1; refr_tick = 1'b0; serve = 1'b0; paddle_y = '0;
        model_reset();
        #2;

        tbl[0] = '{1'b1, 1'b0, 59,  316, 236, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1,   316, 236, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1,   318, 238, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1,   316, 236, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 117, 550, 470, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1,   552, 472, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1,   554, 470, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 38,  630, 394, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1,   632, 392, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1,   630, 390, 1'b1};

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].do_rst) apply_reset($sformatf("reset_%0d", i));
            serve    = tbl[i].srv;
            paddle_y = '0;
            for (int t = 0; t < tbl[i].n_ticks; t++) do_clk(1'b1);
            check_exp($sformatf("table_%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].eplay, 0, 1'b0, 1'b0);
        end
        serve = 1'b0;

        // Track the ball with the paddle until it is returned
        done = 0;
        for (int t = 0; t < 2000 && !done; t++) begin
            paddle_y = 10'(track_pad(m_y));
            do_clk(1'b1);
            check_model("rally_to_hit");
            done = m_hit;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL hit_timeout: no paddle hit within 2000 ticks, required one");
        end else begin
            check_exp("hit_pulse", 36, m_y, 1'b1, 1, 1'b1, 1'b0);
            do_clk(1'b0);
            check_exp("hit_clears", 36, m_y, 1'b1, 1, 1'b0, 1'b0);
        end

        // Keep the paddle away from the ball until it is lost
        done = 0;
        for (int t = 0; t < 2000 && !done; t++) begin
            paddle_y = (m_y < 240) ? 10'd400 : 10'd0;
            do_clk(1'b1);
            check_model("rally_to_miss");
            done = m_miss;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL miss_timeout: no miss within 2000 ticks, required one");
        end else begin
            check_exp("miss_pulse", 0, m_y, 1'b0, m_hits, 1'b0, 1'b1);
            do_clk(1'b0);
            check_model("miss_clears");
            do_clk(1'b1);
            check_exp("miss_recentre", 316, 236, 1'b0, 0, 1'b0, 1'b0);
            do_clk(1'b1);
            check_exp("back_in_serve", 316, 236, 1'b0, 0, 1'b0, 1'b0);
        end

        // Async reset mid-rally
        serve = 1'b1;
        do_clk(1'b1);
        serve = 1'b0;
        for (int t = 0; t < 30; t++) do_clk(1'b1);
        check_model("pre_async_rst");
        apply_reset("async_rst_mid_rally");

        // Randomized play against the model
        for (int n = 0; n < 2000; n++) begin
            serve = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) != 0) paddle_y = 10'(track_pad(m_y));
            else paddle_y = 10'($urandom_range(0, 430));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                do_clk(1'b0);
                check_model($sformatf("rand_idle_%0d", n));
            end
            do_clk(1'b1);
            check_model($sformatf("rand_tick_%0d", n));
            if ($urandom_range(0, 499) == 0) apply_reset($sformatf("rand_rst_%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

endmodule
